romram_checksum: RTL and testbench

Clocked, parametrised successor to the `rom_16`/`ram_4` pair and the ROM-sum experiments built on them. It contains a synchronous ROM, a small synchronous RAM and a start/done FSM. In checksum mode it sums every ROM word except the last, compares the sum with the last word, and writes the sum into a chosen RAM slot. In copy mode it copies a wrap-around window of ROM words into the RAM. It sits behind a host that pulses `start` and reads the results back through a dedicated RAM read port.

---
 rtl/romram_checksum_if.sv | 27 ++
 rtl/romram_checksum.sv | 179 +++++++++++++++++
 tb/tb_romram_checksum.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/romram_checksum_if.sv
// Host-side bus of romram_checksum: launch controls, RAM read port and results.
interface romram_checksum_if #(
  parameter int WIDTH  = 16,
  parameter int ROM_AW = 4,
  parameter int RAM_AW = 2
);
  logic              start;
  logic              mode;
  logic [RAM_AW-1:0] dst;
  logic [ROM_AW-1:0] src;
  logic [RAM_AW-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  sum;
  logic              match;

  modport master (
    output start, mode, dst, src, rd_addr,
    input  rd_data, busy, done, sum, match
  );

  modport slave (
    input  start, mode, dst, src, rd_addr,
    output rd_data, busy, done, sum, match
  );
endinterface

// File: rtl/romram_checksum.sv
// ROM checksum / ROM-to-RAM window copy engine with a start/done handshake
// and a registered host read port into the RAM.
module romram_checksum #(
  parameter int               WIDTH       = 16,
  parameter int               ROM_AW      = 4,
  parameter int               RAM_AW      = 2,
  parameter logic [WIDTH-1:0] CHECK_VALUE = WIDTH'(16'h0069)
) (
  input logic               clock,
  input logic               reset,
  romram_checksum_if.slave  bus
);
  localparam int D = 1 << ROM_AW;
  localparam int R = 1 << RAM_AW;
  localparam logic [ROM_AW-1:0] LAST_ROM  = ROM_AW'(D - 1);
  localparam logic [ROM_AW-1:0] LAST_COPY = ROM_AW'(R - 1);
  localparam logic [RAM_AW-1:0] LAST_SLOT = RAM_AW'(R - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] rom_word(input logic [ROM_AW-1:0] a);
    if (a == LAST_ROM) begin
      rom_word = CHECK_VALUE;
    end else begin
      rom_word = WIDTH'(a);
    end
  endfunction

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [RAM_AW-1:0] dst_q, dst_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [ROM_AW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  rom_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              match_q, match_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  ram_q [R];

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [ROM_AW-1:0] last_cnt;

  // Next-state and datapath control; cnt_q counts addresses already issued,
  // so rom_q holds word (cnt_q-1) of the current sweep while in RUN.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dst_d     = dst_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    match_d   = match_q;
    ram_we    = 1'b0;
    ram_waddr = dst_q;
    ram_wdata = acc_q;
    last_cnt  = mode_q ? LAST_COPY : LAST_ROM;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mode_d  = bus.mode;
          dst_d   = bus.dst;
          addr_d  = bus.mode ? bus.src : {ROM_AW{1'b0}};
          cnt_d   = {ROM_AW{1'b0}};
          acc_d   = {WIDTH{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        addr_d = addr_q + ROM_AW'(1);
        cnt_d  = cnt_q + ROM_AW'(1);
        if (cnt_q != {ROM_AW{1'b0}}) begin
          acc_d = acc_q + rom_q;
          if (mode_q) begin
            ram_we    = 1'b1;
            ram_waddr = RAM_AW'(cnt_q - ROM_AW'(1));
            ram_wdata = rom_q;
          end else begin
            ram_we = 1'b0;
          end
        end else begin
          acc_d = acc_q;
        end
        if (cnt_q == last_cnt) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_WRITE: begin
        // rom_q now holds the final word: the check word or the last copy word
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ram_we  = 1'b1;
        if (mode_q) begin
          ram_waddr = LAST_SLOT;
          ram_wdata = rom_q;
          sum_d     = acc_q + rom_q;
          match_d   = 1'b0;
        end else begin
          ram_waddr = dst_q;
          ram_wdata = acc_q;
          sum_d     = acc_q;
          match_d   = (acc_q == rom_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM, pipeline and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      dst_q   <= {RAM_AW{1'b0}};
      addr_q  <= {ROM_AW{1'b0}};
      cnt_q   <= {ROM_AW{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      rom_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rom_q   <= rom_word(addr_q);
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      match_q <= match_d;
    end
  end

  // RAM array and registered host read (old data on a same-edge write).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < R; i++) begin
        ram_q[i] <= {WIDTH{1'b0}};
      end
      rd_data_q <= {WIDTH{1'b0}};
    end else begin
      if (ram_we) begin
        ram_q[ram_waddr] <= ram_wdata;
      end
      rd_data_q <= ram_q[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.match   = match_q;
endmodule

// File: tb/tb_romram_checksum.sv
// Scoreboard bench for romram_checksum: random launches against an arithmetic
// model, plus mismatch and narrow-width instances.
module tb_romram_checksum;
  localparam int D = 16;
  localparam int R = 4;

  typedef struct {
    logic [15:0] sum;
    logic        match;
    int          accept;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ram_m [R];
  exp_t sb_q [$];
  exp_t e_h;
  exp_t e_mon;

  int lat_b, lat_c, sum_b, sum_c, match_b, match_c, acc_b, acc_c, dcount;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  romram_checksum_if #(.WIDTH(16), .ROM_AW(4), .RAM_AW(2)) bus_a ();
  romram_checksum_if #(.WIDTH(16), .ROM_AW(4), .RAM_AW(2)) bus_b ();
  romram_checksum_if #(.WIDTH(8),  .ROM_AW(5), .RAM_AW(2)) bus_c ();

  romram_checksum #(.WIDTH(16), .ROM_AW(4), .RAM_AW(2), .CHECK_VALUE(16'h0069))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  romram_checksum #(.WIDTH(16), .ROM_AW(4), .RAM_AW(2), .CHECK_VALUE(16'h0070))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));
  romram_checksum #(.WIDTH(8), .ROM_AW(5), .RAM_AW(2))
    dut_c (.clock(clock), .reset(reset), .bus(bus_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rom_m(input int i);
    return (i == D - 1) ? 32'h69 : i;
  endfunction

  // Model: whole-operation result straight from the summing/copy rules.
  task automatic predict(input int m, input int d, input int s, output exp_t e);
    int acc;
    acc = 0;
    if (m == 0) begin
      for (int i = 0; i < D - 1; i++) acc += rom_m(i);
      acc = acc & 32'hFFFF;
      ram_m[d] = acc;
      e.match = (acc == rom_m(D - 1));
      e.lat = D + 1;
    end else begin
      for (int j = 0; j < R; j++) begin
        ram_m[j] = rom_m((s + j) % D);
        acc += ram_m[j];
      end
      acc = acc & 32'hFFFF;
      e.match = 1'b0;
      e.lat = R + 1;
    end
    e.sum = acc[15:0];
    e.accept = 0;
  endtask

  always @(posedge clock) begin
    #1;
    if (bus_a.done === 1'b1) begin
      chk("done_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e_mon = sb_q.pop_front();
        chk("sum", 32'(bus_a.sum), 32'(e_mon.sum));
        chk("match", 32'(bus_a.match), 32'(e_mon.match));
        chk("latency", 32'(cyc - e_mon.accept), 32'(e_mon.lat));
        chk("busy_at_done", 32'(bus_a.busy), 32'd0);
      end
    end
  end

  task automatic launch(input int m, input int d, input int s);
    exp_t e;
    @(negedge clock);
    predict(m, d, s, e);
    e.accept = cyc + 1;
    sb_q.push_back(e);
    bus_a.start = 1'b1;
    bus_a.mode  = m[0];
    bus_a.dst   = d[1:0];
    bus_a.src   = s[3:0];
    @(negedge clock);
    bus_a.start = 1'b0;
    chk("busy_after_start", 32'(bus_a.busy), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (bus_a.done !== 1'b1 && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("done_within_bound", 32'(n < limit), 32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < R; a++) begin
      @(negedge clock);
      bus_a.rd_addr = a[1:0];
      @(posedge clock);
      #1;
      chk($sformatf("%s_ram%0d", tag, a), 32'(bus_a.rd_data), 32'(ram_m[a]));
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < R; i++) ram_m[i] = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.dst = 2'd0; bus_a.src = 4'd0; bus_a.rd_addr = 2'd0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.dst = 2'd0; bus_b.src = 4'd0; bus_b.rd_addr = 2'd0;
    bus_c.start = 1'b0; bus_c.mode = 1'b0; bus_c.dst = 2'd0; bus_c.src = 5'd0; bus_c.rd_addr = 2'd0;

    do_reset();
    chk("reset_busy", 32'(bus_a.busy), 32'd0);
    chk("reset_done", 32'(bus_a.done), 32'd0);
    chk("reset_match", 32'(bus_a.match), 32'd0);
    chk("reset_sum", 32'(bus_a.sum), 32'd0);
    sweep("reset");

    launch(0, 3, 0);
    wait_done(40);
    sweep("cs_dst3");

    launch(1, 0, 14);
    wait_done(20);
    sweep("copy_src14");

    // Random launches, some with a stray start pulse that must be ignored.
    for (int k = 0; k < 12; k++) begin
      int m, d, s;
      m = int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 15));
      launch(m, d, s);
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) @(negedge clock);
        bus_a.start = 1'b1;
        bus_a.mode  = ~m[0];
        bus_a.dst   = 2'($urandom_range(0, 3));
        @(negedge clock);
        bus_a.start = 1'b0;
      end
      wait_done(40);
      sweep("rand");
    end

    // Abort a checksum run with reset at its 8th edge.
    launch(0, 2, 0);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < R; i++) ram_m[i] = 0;
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    chk("abort_done", 32'(bus_a.done), 32'd0);
    chk("abort_sum", 32'(bus_a.sum), 32'd0);
    dcount = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (bus_a.done === 1'b1) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    sweep("abort");
    launch(0, 1, 0);
    wait_done(40);
    sweep("after_abort");

    // start held high: one run while busy, a second accepted in the done cycle.
    do_reset();
    @(negedge clock);
    bus_a.rd_addr = 2'd1;
    @(negedge clock);
    predict(0, 1, 0, e_h);
    e_h.accept = cyc + 1;
    sb_q.push_back(e_h);
    bus_a.start = 1'b1;
    bus_a.mode  = 1'b0;
    bus_a.dst   = 2'd1;
    wait_done(40);
    chk("held_rd_old", 32'(bus_a.rd_data), 32'd0);
    predict(0, 1, 0, e_h);
    e_h.accept = cyc + 1;
    sb_q.push_back(e_h);
    @(posedge clock);
    #1;
    chk("held_rd_new", 32'(bus_a.rd_data), 32'(ram_m[1]));
    chk("held_second_busy", 32'(bus_a.busy), 32'd1);
    @(negedge clock);
    bus_a.start = 1'b0;
    wait_done(40);
    sweep("held");

    // Mismatching check word and an 8-bit / 32-word instance.
    @(negedge clock);
    acc_b = 0;
    for (int i = 0; i < 15; i++) acc_b += i;
    acc_b = acc_b & 32'hFFFF;
    acc_c = 0;
    for (int i = 0; i < 31; i++) acc_c += i;
    acc_c = acc_c & 32'hFF;
    lat_b = -1; lat_c = -1; sum_b = -1; sum_c = -1; match_b = -1; match_c = -1;
    e_h.accept = cyc + 1;
    bus_b.start = 1'b1;
    bus_c.start = 1'b1;
    @(negedge clock);
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
    repeat (60) begin
      @(posedge clock);
      #1;
      if (bus_b.done === 1'b1) begin
        lat_b = cyc - e_h.accept; sum_b = int'(bus_b.sum); match_b = int'(bus_b.match);
      end
      if (bus_c.done === 1'b1) begin
        lat_c = cyc - e_h.accept; sum_c = int'(bus_c.sum); match_c = int'(bus_c.match);
      end
    end
    chk("mismatch_sum", 32'(sum_b), 32'(acc_b));
    chk("mismatch_match", 32'(match_b), 32'(acc_b == 32'h70));
    chk("mismatch_latency", 32'(lat_b), 32'(D + 1));
    chk("narrow_sum", 32'(sum_c), 32'(acc_c));
    chk("narrow_match", 32'(match_c), 32'(acc_c == 32'h69));
    chk("narrow_latency", 32'(lat_c), 32'(32 + 1));

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
